// File: rtl/clk_div_pkg.sv
// Shared constants for the clk_100m clock-enable divider family.
// Divisor values are cycle counts of the 100 MHz reference.
package clk_div_pkg;

    localparam int REF_CLK_HZ      = 100_000_000;
    localparam int DIV_W_DEF       = 16;
    localparam int DEFAULT_DIV_DEF = 100;

    localparam int DIV_1MHZ   = 100;
    localparam int DIV_1KHZ   = 100_000;   // needs DIV_W >= 17
    localparam int DIV_115200 = 868;

    // Rounded-down divisor for a target enable rate.
    function automatic int div_for_hz(input int hz);
        return (hz > 0) ? (REF_CLK_HZ / hz) : 0;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, live and shadow divisor, registered tick/square outputs.
// Optional CLK_DIV_PENDING_EN adds a flag showing a written divisor not yet in use.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk_100m,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             we,
    input  logic [DIV_W-1:0] wdata,
    output logic             tick_o,
    output logic             sq_o
`ifdef CLK_DIV_PENDING_EN
    ,
    output logic             pending
`endif
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] shadow;
    logic [DIV_W-1:0] last;
    logic [DIV_W-1:0] half_m1;
    logic [DIV_W-1:0] div_src;
    logic             run;
    logic             wrap;
    logic             copy;

    // The live divisor only moves when the counter is (or is about to be) at zero,
    // so a reprogram never produces a truncated period.
    always_comb begin
        last    = div_r - DIV_W'(1);
        half_m1 = (div_r >> 1) - DIV_W'(1);
        run     = en && !sync && (div_r != '0);
        wrap    = run && (cnt == last);
        copy    = sync || !en || (div_r < DIV_W'(2)) || wrap;
        div_src = (sync && we) ? wdata : shadow;
    end

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            cnt    <= '0;
            div_r  <= DIV_W'(DEFAULT_DIV);
            shadow <= DIV_W'(DEFAULT_DIV);
            tick_o <= 1'b0;
            sq_o   <= 1'b0;
        end else begin
            if (we) begin
                shadow <= wdata;
            end
            if (copy) begin
                div_r <= div_src;
            end
            if (!run) begin
                cnt    <= '0;
                tick_o <= 1'b0;
                sq_o   <= 1'b0;
            end else if (wrap) begin
                cnt    <= '0;
                tick_o <= 1'b1;
                sq_o   <= (div_r != DIV_W'(1));
            end else begin
                cnt    <= cnt + DIV_W'(1);
                tick_o <= 1'b0;
                if (cnt == half_m1) begin
                    sq_o <= 1'b0;
                end
            end
        end
    end

`ifdef CLK_DIV_PENDING_EN
    // A write coincident with sync is consumed at once, so it never becomes pending.
    always_ff @(posedge clk_100m) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (we && !sync) begin
            pending <= 1'b1;
        end else if (copy) begin
            pending <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/clk_div_multi.sv
// N-channel clock-enable generator in the clk_100m domain: address decode, sync fan-out.
// Define CLK_DIV_PENDING_EN to expose per-channel cfg_pending flags.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int DIV_W       = DIV_W_DEF,
    parameter  int DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_100m,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] sq_o
`ifdef CLK_DIV_PENDING_EN
    ,
    output logic [NUM_CH-1:0] cfg_pending
`endif
);

    logic [NUM_CH-1:0] ch_we;

    // Out-of-range addresses match no channel and are dropped.
    always_comb begin
        ch_we = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_we[i] = cfg_we && (int'(cfg_ch) == i);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_100m (clk_100m),
            .rst      (rst),
            .en       (en[i]),
            .sync     (sync),
            .we       (ch_we[i]),
            .wdata    (cfg_div),
            .tick_o   (tick_o[i]),
            .sq_o     (sq_o[i])
`ifdef CLK_DIV_PENDING_EN
            ,
            .pending  (cfg_pending[i])
`endif
        );
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised N-channel clock-enable generator; next generation of the fixed 100 MHz to 1 MHz toggle divider.
- Each channel produces:
  - a single-cycle tick_o pulse every D cycles;
  - a near-50% sq_o waveform.
- D is programmable per channel at runtime.
- Sits in the clk_100m domain. Feeds UART baud, PWM, debounce and display-scan blocks as clock enables; never as derived clocks.

Parameters:
- NUM_CH, 4, number of independent channels (1..16)
- DIV_W, 16, divisor width in bits
- DEFAULT_DIV, 100, divisor loaded on reset in every channel (100 gives a 1 MHz tick)
- CH_W, $clog2(NUM_CH) (min 1), channel-select width; derived, not overridden

Ports:
- clk_100m  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- en  in  NUM_CH  per-channel run enable
- sync  in  1  one-cycle pulse; restarts all channels in phase
- cfg_we  in  1  divisor write strobe
- cfg_ch  in  CH_W  channel addressed by cfg_we
- cfg_div  in  DIV_W  new divisor value D
- tick_o  out  NUM_CH  registered 1-cycle enable pulse per channel
- sq_o  out  NUM_CH  registered square wave per channel

Behaviour:
- Reset (rst high at a clk_100m edge): div_r=shadow=DEFAULT_DIV, cnt=0, tick_o=0, sq_o=0 for all channels. rst overrides every other input.
- Per channel: cnt counts 0..D-1 while en=1. At the edge with cnt==D-1: cnt<=0 and tick_o<=1. At every other edge: tick_o<=0.
- Latency: with en raised before edge 1, the first tick_o is high after exactly D edges, then repeats every D cycles, 1 cycle wide.
- sq_o:
  - Set at the wrap edge, so the rise aligns with tick_o.
  - Cleared at the edge where cnt==(D>>1)-1.
  - Even D gives 50% duty; odd D gives a high phase of floor(D/2) cycles.
- D=1: tick_o held high continuously, sq_o held 0.
- D=0: channel stopped; cnt=0, tick_o=0, sq_o=0.
- en low: cnt<=0, tick_o<=0, sq_o<=0 at the next edge. Re-enable restarts from cnt=0 with full latency D.
- cfg write: cfg_we with cfg_ch<NUM_CH loads the shadow register. cfg_ch>=NUM_CH is ignored.
- div_r update timing:
  - div_r<=shadow at the next wrap edge (glitch-free, no truncated period).
  - Immediate if the channel is disabled or the current div_r is 0 or 1.
- Write during a wrap edge: the old shadow is applied at that edge. The new value waits for the following wrap.
- Repeated writes before a wrap: the last one wins.
- sync:
  - At the sync edge, every enabled channel gets cnt<=0, sq_o<=0, tick_o<=0, and div_r<=shadow.
  - sync coincident with cfg_we: the freshly written value is used by the addressed channel.
  - Disabled channels ignore sync except for the shadow transfer.
- Counter arithmetic: unsigned, DIV_W bits. Comparisons are against div_r-1. Wrap never overflows because D<=2^DIV_W-1.

Optional Feature:
- Macro CLK_DIV_PENDING_EN.
- When defined: adds output cfg_pending [NUM_CH].
  - Bit set at the edge after an accepted write.
  - Bit cleared at the edge that copies shadow into div_r.
  - Reset value 0.
- When undefined: port and logic absent. Divisor behaviour is identical.

Decomposition:
- Package clk_div_pkg holds:
  - DIV_W default;
  - DEFAULT_DIV;
  - the 100 MHz reference constant;
  - named divisor constants DIV_1MHZ=100, DIV_1KHZ=100000 (needs DIV_W>=17), DIV_115200=868.
- Sub-module clk_div_chan implements one channel: cnt, div_r, shadow, tick/sq registers and the optional pending bit.
- clk_div_multi does cfg_ch decode, sync fan-out and generate-instantiates NUM_CH copies.

Test Plan:
- Reset, default divisor: rst high 3 cycles, then en=4'b0001. Check:
  - tick_o[0] first high exactly 100 cycles after en;
  - period 100, width 1;
  - sq_o[0] high 50 / low 50;
  - channels 1-3 stay 0.
- Glitch-free reprogram: ch0 running at D=10, write cfg_div=4 mid-period (cnt=3). Check:
  - the current period completes at 10 cycles;
  - subsequent periods are 4;
  - with CLK_DIV_PENDING_EN, cfg_pending[0] is high from the write+1 edge until the wrap.
- Odd divisor and extremes:
  - D=5: sq_o high 2, low 3.
  - D=1: tick_o constant 1, sq_o 0.
  - D=0: all outputs 0.
  - D=2: tick every 2 cycles, sq_o toggles every cycle.
- Sync alignment: ch0 D=6 and ch1 D=3, started at different times; pulse sync. Check:
  - both tick at cycle sync+3 (ch1) and sync+6 (ch0, coincident with ch1);
  - sq_o of both is 0 in the cycle after sync.
- Simultaneous and invalid writes:
  - cfg_we and sync in the same cycle on ch2 with cfg_div=8: ch2 period is 8 immediately.
  - cfg_ch=5 with NUM_CH=4: no channel changes.
- Mid-operation reset and disable:
  - rst asserted at cnt=57 (D=100): all outputs 0 next edge, div_r back to 100 even after an earlier write of 20.
  - en dropped at cnt=30 then restored: next tick exactly 100 cycles after restore.
